// File: rtl/fifo_arb_pkg.sv
// Shared state type and sizing helpers for the FIFO push-side burst arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_BURST} arb_state_e;

    // Beat counter must hold 0..MAX_BURST.
    function automatic int beat_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    function automatic int index_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after prio_ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = index_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   prio_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    int   cand;
    logic found;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(prio_ptr) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                pick[cand]  = 1'b1;
                pick_idx    = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing the FIFO push port among NUM_REQ producers;
// one owner is locked per burst and fifo_full back-pressure stalls the owner.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [DATA_WIDTH-1:0] req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    grant,
    input  logic                  fifo_full,
    output logic                  fifo_push,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  busy
);

    localparam int IDX_W = index_width(NUM_REQ);
    localparam int CNT_W = beat_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_e         state, state_next;
    logic [IDX_W-1:0]   owner, owner_next;
    logic [IDX_W-1:0]   prio_ptr, prio_ptr_next;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] grant_next, pick;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_next;
    logic               accept, burst_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (req_valid),
        .prio_ptr (prio_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            grant    <= '0;
            prio_ptr <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            grant    <= grant_next;
            prio_ptr <= prio_ptr_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    // Beats move only while bursting and the FIFO has room.
    always_comb begin
        accept    = (state == ARB_BURST) && req_valid[owner] && !fifo_full;
        burst_end = accept && (req_last[owner] || (beat_cnt == LAST_BEAT));
        fifo_push = accept;
        fifo_data = (state == ARB_BURST) ? req_data[owner] : '0;
        req_ready = '0;
        if (accept) begin
            req_ready[owner] = 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        owner_next    = owner;
        grant_next    = grant;
        prio_ptr_next = prio_ptr;
        beat_cnt_next = beat_cnt;
        case (state)
            ARB_IDLE: begin
                if (|req_valid) begin
                    state_next    = ARB_BURST;
                    owner_next    = pick_idx;
                    grant_next    = pick;
                    beat_cnt_next = '0;
                end
            end
            ARB_BURST: begin
                if (burst_end) begin
                    state_next    = ARB_IDLE;
                    grant_next    = '0;
                    prio_ptr_next = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
                end else if (accept) begin
                    beat_cnt_next = beat_cnt + CNT_W'(1);
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign busy = (state == ARB_BURST);

endmodule
